// File: rtl/cls_ctrl_pkg.sv
// Shared types and constants for the classify sequencer.
//   - cls_state_e       : sequencer FSM states
//   - CLS_TIMEOUT_CLASS : class reported when the comparator never answers
//   - DEC_INDEX_BITS    : width of the image sequence number
package cls_ctrl_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } cls_state_e;

  localparam logic [3:0] CLS_TIMEOUT_CLASS = 4'hF;
  localparam int         DEC_INDEX_BITS    = 16;

endpackage

// File: rtl/cls_wait_timer.sv
// Comparator-response watchdog. Counts cycles while enable is high and
// flags expired on the TIMEOUT_CYC-th enabled cycle, so the owner can leave
// its wait state on that same edge. clear zeroes the count.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the counter
//   enable    : count this cycle
//   expired   : combinational, high on the last allowed enabled cycle
module cls_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/classify_sequencer.sv
// Frames the FC class-score stream into images of NUM_CLASS scores for the
// external argmax comparator, clears the comparator between images, waits
// for its result pulse and presents each decision with an image index.
// Optional feature macro: CLS_TIMEOUT_EN (comparator response watchdog).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   score_valid/ready/data          : upstream score stream
//   cmp_rst/valid_in/data           : to comparator
//   cmp_valid_out, cmp_decision     : from comparator
//   dec_valid/ready/class/index     : downstream decision
//   busy                            : high outside CLEAR
//   err_timeout                     : sticky watchdog flag
module classify_sequencer
  import cls_ctrl_pkg::*;
#(
  parameter int SCORE_BITS  = 12,
  parameter int NUM_CLASS   = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      score_valid,
  output logic                      score_ready,
  input  logic [SCORE_BITS-1:0]     score_data,
  output logic                      cmp_rst,
  output logic                      cmp_valid_in,
  output logic [SCORE_BITS-1:0]     cmp_data,
  input  logic                      cmp_valid_out,
  input  logic [3:0]                cmp_decision,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [3:0]                dec_class,
  output logic [DEC_INDEX_BITS-1:0] dec_index,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(NUM_CLASS);
  localparam logic [CNT_W-1:0] LAST_SCORE = CNT_W'(NUM_CLASS - 1);

  cls_state_e                state_q, state_d;
  logic [CNT_W-1:0]          score_cnt_q, score_cnt_d;
  logic                      dec_valid_q, dec_valid_d;
  logic [3:0]                dec_class_q, dec_class_d;
  logic [DEC_INDEX_BITS-1:0] dec_index_q, dec_index_d;

`ifdef CLS_TIMEOUT_EN
  logic timeout_hit;
  logic err_timeout_q, err_timeout_d;

  cls_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == CLEAR),
    .enable  (state_q == WAIT),
    .expired (timeout_hit)
  );

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Stream-side outputs depend on state only (plus the data pass-through),
  // so score_ready never combinationally follows score_valid.
  assign score_ready  = (state_q == LOAD);
  assign cmp_valid_in = (state_q == LOAD) && score_valid;
  assign cmp_data     = (state_q == LOAD) ? score_data : '0;
  assign cmp_rst      = rst || (state_q == CLEAR);
  assign busy         = (state_q != CLEAR);
  assign dec_valid    = dec_valid_q;
  assign dec_class    = dec_class_q;
  assign dec_index    = dec_index_q;

  always_comb begin
    state_d     = state_q;
    score_cnt_d = score_cnt_q;
    dec_valid_d = dec_valid_q;
    dec_class_d = dec_class_q;
    dec_index_d = dec_index_q;
`ifdef CLS_TIMEOUT_EN
    err_timeout_d = err_timeout_q;
`endif
    case (state_q)
      CLEAR: begin
        score_cnt_d = '0;
        state_d     = LOAD;
      end
      LOAD: begin
        if (score_valid) begin
          if (score_cnt_q == LAST_SCORE) begin
            score_cnt_d = '0;
            state_d     = WAIT;
          end else begin
            score_cnt_d = score_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // A real result wins over a watchdog expiry on the same cycle.
        if (cmp_valid_out) begin
          dec_class_d = cmp_decision;
          dec_valid_d = 1'b1;
          state_d     = HOLD;
        end
`ifdef CLS_TIMEOUT_EN
        else if (timeout_hit) begin
          dec_class_d   = CLS_TIMEOUT_CLASS;
          dec_valid_d   = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = HOLD;
        end
`endif
      end
      HOLD: begin
        if (dec_ready) begin
          dec_valid_d = 1'b0;
          dec_index_d = dec_index_q + 1'b1;
          state_d     = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      score_cnt_q <= '0;
      dec_valid_q <= 1'b0;
      dec_class_q <= '0;
      dec_index_q <= '0;
`ifdef CLS_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      score_cnt_q <= score_cnt_d;
      dec_valid_q <= dec_valid_d;
      dec_class_q <= dec_class_d;
      dec_index_q <= dec_index_d;
`ifdef CLS_TIMEOUT_EN
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

endmodule

// File: doc/classify_sequencer.md
# classify_sequencer

Sequencer for the final argmax comparator of the MNIST CNN. It accepts the fully-connected layer's class-score stream through a valid/ready handshake and frames it into images of NUM_CLASS scores. It pulses the comparator's reset between images, feeds the scores, waits for the comparator's one-cycle result pulse, and presents each decision downstream with an image index until it is accepted. It sits between the FC output stage and the top-level result interface.

## Interface
- SCORE_BITS, 12, signed score width; matches the comparator's input width
- NUM_CLASS, 10, scores per image (2..15)
- TIMEOUT_CYC, 64, WAIT cycles before a timeout is declared (CLS_TIMEOUT_EN only)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- score_valid  in  1  upstream score valid
- score_ready  out  1  upstream score ready
- score_data  in  SCORE_BITS  signed class score
- cmp_rst  out  1  comparator reset
- cmp_valid_in  out  1  comparator input strobe
- cmp_data  out  SCORE_BITS  comparator input data
- cmp_valid_out  in  1  comparator result pulse
- cmp_decision  in  4  comparator argmax index
- dec_valid  out  1  decision valid
- dec_ready  in  1  decision accepted
- dec_class  out  4  winning class
- dec_index  out  16  image sequence number
- busy  out  1  high in every state except CLEAR
- err_timeout  out  1  sticky comparator timeout flag

## Operation
- FSM states: CLEAR → LOAD → WAIT → HOLD → CLEAR.
- **CLEAR** (1 cycle):
  - cmp_rst=1; score_ready=0.
  - Zero the score counter and the wait counter.
  - Next state: LOAD.
- **LOAD**:
  - score_ready=1; cmp_valid_in = score_valid; cmp_data = score_data (combinational pass-through).
  - A transfer is an edge with score_valid & score_ready; each transfer increments score_cnt.
  - Gaps in score_valid are allowed; the comparator holds its state while idle.
  - The edge accepting transfer NUM_CLASS-1 (0-based) moves the FSM to WAIT.
- **WAIT**:
  - score_ready=0; cmp_valid_in=0.
  - On cmp_valid_out=1: capture cmp_decision into dec_class, then go to HOLD.
- **HOLD**:
  - dec_valid=1; dec_class and dec_index are held stable.
  - On dec_ready=1: dec_index increments (wraps 0xFFFF→0x0000), then go to CLEAR.
- cmp_rst = rst | (state==CLEAR), so the comparator is cleared during reset and between images.
- cmp_valid_out seen outside WAIT is ignored (stale pulse).
- **Reset values**:
  - State: CLEAR.
  - score_ready=0, cmp_valid_in=0, cmp_data=0.
  - dec_valid=0, dec_class=0, dec_index=0.
  - busy=0, err_timeout=0.
- **Reset mid-image**: the partial image is discarded, no decision is produced, and dec_index returns to 0.
- **dec_ready while dec_valid=0**: ignored.

## Timing
- Decision latency: with a nominal comparator, dec_valid rises 7 edges after the edge accepting the last score.
  - Comparator result pulse appears after the 6th idle edge.
  - The controller captures it on the 7th.
- Minimum image period: NUM_CLASS + 9 cycles (1 CLEAR + NUM_CLASS LOAD + 7 WAIT + 1 HOLD, with immediate dec_ready).
- score_ready depends only on state; there is no combinational path from score_valid.
- dec_valid and dec_class are registered.

## Configuration
- Macro: CLS_TIMEOUT_EN.
- **Defined**:
  - A wait counter runs in WAIT.
  - If it reaches TIMEOUT_CYC with no cmp_valid_out: set err_timeout (sticky until rst), load dec_class=4'hF, go to HOLD.
  - The image is then handshaken and counted normally.
- **Undefined**:
  - No counter; WAIT lasts indefinitely.
  - err_timeout is tied to 0.

## Structure
- Shared package cls_ctrl_pkg holds:
  - State enum (CLEAR, LOAD, WAIT, HOLD).
  - CLS_TIMEOUT_CLASS = 4'hF.
  - DEC_INDEX_BITS = 16.
- One sub-module: cls_wait_timer, the timeout counter present only under CLS_TIMEOUT_EN (inputs clear/enable, output expired).
- The comparator is instantiated beside this block in the parent, not inside it.

## Test plan
- Reset, then 10 back-to-back scores {3,-7,12,40,5,0,-1,39,2,8} → 1-cycle cmp_rst pulse; dec_valid 7 edges after the last transfer; dec_class=3; dec_index=0.
- Same image with score_valid toggling every other cycle, dec_ready held low 5 cycles → score_ready never drops mid-image; dec_class=3 held stable through HOLD; dec_index=1 for the following image.
- Scores all -2048 except index 9 = 2047 → dec_class=9. Tie at indices 2 and 6 → dec_class=2.
- rst asserted after 4 scores, then a full image → no dec_valid for the partial image; next decision carries dec_index=0.
- CLS_TIMEOUT_EN defined, cmp_valid_out forced low → err_timeout=1 after 64 WAIT cycles; dec_class=4'hF. Next image completes normally with err_timeout still 1.
- 65536 images with dec_ready tied 1 → dec_index wraps to 0x0000.
